// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory
// over a req/ack handshake, holds one instruction for decode and handles
// branch/jump redirects (including squashing an in-flight fetch).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    output logic [31:0] currInstr,
    output logic [31:0] currPC,
    output logic        instrValid,
    input  logic        decodeReady,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic        fetchMisaligned,
    output logic [31:0] fetchCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] reqAddr_q, reqAddr_d;
    logic        squash_q, squash_d;
    logic        instrValid_q, instrValid_d;
    logic [31:0] currInstr_q, currInstr_d;
    logic [31:0] currPC_q, currPC_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] fetchCount_q, fetchCount_d;

    // State register; reset drops any outstanding request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            reqAddr_q    <= RESET_PC;
            squash_q     <= 1'b0;
            instrValid_q <= 1'b0;
            currInstr_q  <= NOP_INSTR;
            currPC_q     <= 32'h0000_0000;
            misaligned_q <= 1'b0;
            fetchCount_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            reqAddr_q    <= reqAddr_d;
            squash_q     <= squash_d;
            instrValid_q <= instrValid_d;
            currInstr_q  <= currInstr_d;
            currPC_q     <= currPC_d;
            misaligned_q <= misaligned_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    // Next-state logic: a redirect outranks normal sequencing; ERR is terminal.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        reqAddr_d    = reqAddr_q;
        squash_d     = squash_q;
        instrValid_d = instrValid_q;
        currInstr_d  = currInstr_q;
        currPC_d     = currPC_q;
        misaligned_d = misaligned_q;
        fetchCount_d = fetchCount_q;

        if (state_q == ERR) begin
            instrValid_d = 1'b0;
        end else if (redirectValid) begin
            if (redirectTarget[1:0] != 2'b00) begin
                state_d      = ERR;
                misaligned_d = 1'b1;
                instrValid_d = 1'b0;
                currInstr_d  = NOP_INSTR;
                squash_d     = 1'b0;
            end else begin
                unique case (state_q)
                    IDLE, HOLD: begin
                        pc_d         = redirectTarget;
                        reqAddr_d    = redirectTarget;
                        instrValid_d = 1'b0;
                        currInstr_d  = NOP_INSTR;
                        state_d      = FETCH;
                        if (state_q == HOLD && decodeReady) begin
                            fetchCount_d = fetchCount_q + 32'd1;
                        end
                    end
                    FETCH: begin
                        pc_d = redirectTarget;
                        if (imemAck) begin
                            squash_d  = 1'b0;
                            reqAddr_d = redirectTarget;
                        end else begin
                            squash_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    reqAddr_d = pc_q;
                    state_d   = FETCH;
                end
                FETCH: begin
                    if (imemAck) begin
                        if (squash_q) begin
                            squash_d  = 1'b0;
                            reqAddr_d = pc_q;
                        end else begin
                            currInstr_d  = imemRdata;
                            currPC_d     = reqAddr_q;
                            instrValid_d = 1'b1;
                            pc_d         = reqAddr_q + 32'd4;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (decodeReady) begin
                        instrValid_d = 1'b0;
                        currInstr_d  = NOP_INSTR;
                        fetchCount_d = fetchCount_q + 32'd1;
                        reqAddr_d    = pc_q;
                        state_d      = FETCH;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign imemReq         = (state_q == FETCH);
    assign imemAddr        = reqAddr_q;
    assign currInstr       = currInstr_q;
    assign currPC          = currPC_q;
    assign instrValid      = instrValid_q;
    assign fetchMisaligned = misaligned_q;
    assign fetchCount      = fetchCount_q;

endmodule
